// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder:
// FSM state encoding, word geometry and the request address check.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  // A request is in error when it is misaligned, or when it falls
  // outside [base, base + WORD_BYTES*2^depth_log2).
  // Arithmetic is 32-bit unsigned; the span uses 33 bits so a
  // 4 GiB window cannot wrap to zero.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth_log2);
    logic [32:0] span;
    logic [32:0] off;
    span = 33'(WORD_BYTES) << depth_log2;
    off  = {1'b0, addr - base};
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (addr < base) || (off >= span);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the memory responder
// (slave): request and response each use their own valid/ready pair.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_word_ram.sv
// Single-port word RAM with registered read. The read register only
// updates when re_i is high, so read data stays put between accesses.
module word_ram #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] rdata_q;

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time,
// waits WAIT_CYCLES busy cycles, then presents a held response until the
// initiator takes it. RAM is touched only on the edge entering RESP.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  write_q;
  logic                  err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic                  rd_sel_q;

  logic                  in_err;
  logic [31:0]           in_off;
  logic [DEPTH_LOG2-1:0] in_idx;

  logic                  commit_d;
  logic                  c_write_d;
  logic                  c_err_d;
  logic [DEPTH_LOG2-1:0] c_idx_d;
  logic [31:0]           c_wdata_d;
  logic [31:0]           ram_rdata;

  // Decode of the request currently on the bus; the index is only
  // meaningful when in_err is low.
  assign in_err = addr_err(bus.req_addr, BASE_ADDR, DEPTH_LOG2);
  assign in_off = bus.req_addr - BASE_ADDR;
  assign in_idx = DEPTH_LOG2'(in_off >> 2);

  // Commit source: with no wait states the accepting edge is also the
  // commit edge, so the live bus feeds the RAM; otherwise the captured copy.
  always_comb begin
    commit_d  = 1'b0;
    c_write_d = write_q;
    c_err_d   = err_q;
    c_idx_d   = idx_q;
    c_wdata_d = wdata_q;
    if (ZERO_WAIT) begin
      commit_d  = (state_q == ST_IDLE) && bus.req_valid;
      c_write_d = bus.req_write;
      c_err_d   = in_err;
      c_idx_d   = in_idx;
      c_wdata_d = bus.req_wdata;
    end else begin
      commit_d  = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    end
  end

  word_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .we_i   (commit_d && c_write_d && !c_err_d),
    .re_i   (commit_d && !c_write_d && !c_err_d),
    .addr_i (c_idx_d),
    .wdata_i(c_wdata_d),
    .rdata_o(ram_rdata)
  );

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            err_q       <= in_err;
            idx_q       <= in_idx;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (ZERO_WAIT) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_BUSY;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // Entering RESP: latch the response flags alongside the RAM access.
      if (commit_d) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= c_err_d;
        rd_sel_q     <= !c_err_d && !c_write_d;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  // Load data comes straight from the RAM read register, gated to zero
  // for stores, errors and outside RESP.
  assign bus.resp_rdata = rd_sel_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three builds side by side
// (WAIT=2/base 0, WAIT=0/base 0, WAIT=2/base 0x1001_0000).
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        rv  [3];
  logic        rw  [3];
  logic [31:0] ra  [3];
  logic [31:0] rwd [3];
  logic        rr  [3];
  logic        qr  [3];
  logic        pv  [3];
  logic [31:0] pd  [3];
  logic        pe  [3];

  dmem_responder_if bus_if [3] ();

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      assign bus_if[gi].req_valid  = rv[gi];
      assign bus_if[gi].req_write  = rw[gi];
      assign bus_if[gi].req_addr   = ra[gi];
      assign bus_if[gi].req_wdata  = rwd[gi];
      assign bus_if[gi].resp_ready = rr[gi];
      assign qr[gi] = bus_if[gi].req_ready;
      assign pv[gi] = bus_if[gi].resp_valid;
      assign pd[gi] = bus_if[gi].resp_rdata;
      assign pe[gi] = bus_if[gi].resp_err;

      dmem_responder #(
        .DEPTH_LOG2 (8),
        .WAIT_CYCLES((gi == 1) ? 0 : 2),
        .BASE_ADDR  ((gi == 2) ? 32'h1001_0000 : 32'h0000_0000)
      ) u_dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus_if[gi].slave)
      );
    end
  endgenerate

  typedef struct {
    int          sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          bp;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int exp_wait(input int sel);
    return (sel == 1) ? 0 : 2;
  endfunction

  // Wait (bounded) for req_ready, then present the request for one edge.
  task automatic accept(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd);
    int t = 0;
    while (!qr[sel] && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("req_ready_before_accept", {31'd0, qr[sel]}, 32'd1);
    rv[sel] = 1'b1; rw[sel] = wr; ra[sel] = addr; rwd[sel] = wd;
    @(posedge clk); #1;
    rv[sel] = 1'b0;
  endtask

  // Full transaction: accept, measure latency, hold backpressure, handshake.
  task automatic xact(input int idx, input vec_t v);
    int lat = 0;
    accept(v.sel, v.wr, v.addr, v.wd);
    while (!pv[v.sel] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, exp_wait(v.sel));
    chk("resp_rdata", pd[v.sel], v.exp_rd);
    chk("resp_err", {31'd0, pe[v.sel]}, {31'd0, v.exp_err});
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", {31'd0, pv[v.sel]}, 32'd1);
      chk("bp_rdata", pd[v.sel], v.exp_rd);
      chk("bp_req_ready", {31'd0, qr[v.sel]}, 32'd0);
    end
    if (v.sel != 1) rr[v.sel] = 1'b1;
    @(posedge clk); #1;
    if (v.sel != 1) rr[v.sel] = 1'b0;
    chk("post_resp_valid", {31'd0, pv[v.sel]}, 32'd0);
    chk("post_req_ready", {31'd0, qr[v.sel]}, 32'd1);
    chk("post_rdata", pd[v.sel], 32'd0);
    $display("txn %0d dut%0d %s addr=%h wd=%h lat=%0d", idx, v.sel,
             v.wr ? "ST" : "LD", v.addr, v.wd, lat);
  endtask

  task automatic chk_reset_outputs(input int sel, input string tag);
    chk({tag, "_req_ready"}, {31'd0, qr[sel]}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, pv[sel]}, 32'd0);
    chk({tag, "_resp_rdata"}, pd[sel], 32'd0);
    chk({tag, "_resp_err"}, {31'd0, pe[sel]}, 32'd0);
  endtask

  vec_t vecs [17];
  vec_t v;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 32'd0; rwd[i] = 32'd0;
      rr[i] = (i == 1);
    end

    //          sel wr    addr            wdata          exp_rd         err   bp
    vecs[0]  = '{0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0, 0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[2]  = '{0, 1'b0, 32'h0000_0041, 32'h0,         32'h0,         1'b1, 0};
    vecs[3]  = '{0, 1'b1, 32'h0000_0400, 32'h7777_7777, 32'h0,         1'b1, 0};
    vecs[4]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 0};
    vecs[5]  = '{0, 1'b1, 32'h0000_03FC, 32'h1122_3344, 32'h0,         1'b0, 0};
    vecs[6]  = '{0, 1'b0, 32'h0000_03FC, 32'h0,         32'h1122_3344, 1'b0, 0};
    vecs[7]  = '{0, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, 5};
    vecs[8]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 0};
    vecs[9]  = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0, 0};
    vecs[10] = '{1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,         1'b0, 0};
    vecs[11] = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'hCAFE_F00D, 1'b0, 0};
    vecs[12] = '{2, 1'b1, 32'h1001_03FC, 32'hA5A5_A5A5, 32'h0,         1'b0, 0};
    vecs[13] = '{2, 1'b0, 32'h1001_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0, 0};
    vecs[14] = '{2, 1'b0, 32'h1000_FFFC, 32'h0,         32'h0,         1'b1, 0};
    vecs[15] = '{2, 1'b0, 32'h1001_0400, 32'h0,         32'h0,         1'b1, 0};
    vecs[16] = '{2, 1'b0, 32'h1001_0000, 32'h0,         32'h0,         1'b0, 0};

    #2 rst_n = 1'b0;
    #20;
    for (int i = 0; i < 3; i++) chk_reset_outputs(i, "init_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) xact(i, vecs[i]);

    // Reset during BUSY discards the pending store.
    accept(0, 1'b1, 32'h0000_0080, 32'h1234_5678);
    chk("busy_resp_valid", {31'd0, pv[0]}, 32'd0);
    chk("busy_req_ready", {31'd0, qr[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "busy_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_outputs(0, "busy_reset_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{0, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b0, 0};
    xact(100, v);

    // Reset after the commit edge (in RESP) keeps the stored word.
    accept(0, 1'b1, 32'h0000_0084, 32'h55AA_55AA);
    begin
      int t = 0;
      while (!pv[0] && t < 50) begin
        @(posedge clk); #1; t++;
      end
      chk("resp_before_reset", {31'd0, pv[0]}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "resp_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{0, 1'b0, 32'h0000_0084, 32'h0, 32'h55AA_55AA, 1'b0, 0};
    xact(101, v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
